rdmap_hdr_dispatch: RTL

Parametrised next-generation RDMAP header dispatcher between the DDP header output and the RDMAP operator FIFOs/IRRQ. It classifies each header by opcode and routes it to the ack, write-done, read-done or request paths. For SEND it tracks a per-TID segment counter with SOP/EOP detection, including read-after-write forwarding for back-to-back same-TID segments. Unlike its predecessor it adds input backpressure, a startup table-init sweep, illegal-input error counting and a send-complete (EOP) FIFO.

---
 rtl/rdmap_pkg.sv | 27 ++
 rtl/gen_ram_2p.sv | 30 +++
 rtl/rdmap_hdr_dispatch.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rdmap_pkg.sv
// Shared opcode encoding and header field offsets for the RDMAP header dispatcher.
package rdmap_pkg;

  typedef enum logic [3:0] {
    SEND    = 4'h0,
    RCV     = 4'h1,
    REQ     = 4'h3,
    RD_DONE = 4'h4,
    WR_DONE = 4'h6,
    ACK     = 4'h7
  } opcode_e;

  localparam int SEND_TID_LSB = 40;
  localparam int ACK_TID_LSB  = 36;
  localparam int QNUM_LSB     = 20;
  localparam int QNUM_W       = 16;

  // Legal opcodes have a zero upper nibble and one of the defined low-nibble codes.
  function automatic logic op_legal(input logic [7:0] ctl);
    if (ctl[7:4] != 4'h0) return 1'b0;
    case (ctl[3:0])
      SEND, RCV, REQ, RD_DONE, WR_DONE, ACK: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gen_ram_2p.sv
// Simple dual-port RAM: one write port and one registered read port that
// returns the old contents on a same-address collision.
module gen_ram_2p #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array is deliberately not reset so it maps onto block RAM; the owner clears it with a sweep.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rdmap_hdr_dispatch.sv
// RDMAP header dispatcher: classifies DDP headers by opcode, routes them to the
// operator FIFOs/IRRQ and tracks per-TID SEND segment counts with SOP/EOP detection.
module rdmap_hdr_dispatch
  import rdmap_pkg::*;
#(
  parameter int TID_W = 8,
  parameter int CNT_W = 3,
  parameter int ERR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hdrValid,
  output logic              hdrReady,
  input  logic [7:0]        hdrControl,
  input  logic [47:0]       hdrData,
  output logic              ackFifoPush,
  output logic [23:0]       ackFifoDataIn,
  input  logic              ackFifoAFull,
  output logic              wrDoneFifoPush,
  output logic [TID_W-1:0]  wrDoneFifoDataIn,
  input  logic              wrDoneFifoAFull,
  output logic              rdDoneFifoPush,
  output logic [TID_W-1:0]  rdDoneFifoDataIn,
  input  logic              rdDoneFifoAFull,
  output logic              offloadFifoPush,
  output logic [TID_W-1:0]  offloadFifoDataIn,
  output logic              eopFifoPush,
  output logic [TID_W-1:0]  eopFifoDataIn,
  input  logic              eopFifoAFull,
  input  logic              offloadFifoAFull,
  output logic              reqValid,
  output logic [47:0]       reqInfo,
  output logic              dataNumRd,
  output logic [TID_W-1:0]  dataNumRdAddr,
  input  logic [CNT_W-1:0]  dataNumRdData,
  input  logic              queueNumRd,
  input  logic [TID_W-1:0]  queueNumRdAddr,
  output logic [15:0]       queueNumRdData,
  output logic              initDone,
  output logic [ERR_W-1:0]  errCount
);

  localparam int DEPTH = 1 << TID_W;

  logic              init_done;
  logic [TID_W-1:0]  init_addr;
  logic              accept, legal, s0_send, s0_ack, s0_err;
  logic [TID_W-1:0]  send_tid, ack_tid;

  // Both tables are cleared one address per cycle after reset; no header is accepted until then.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      init_done <= 1'b0;
      init_addr <= '0;
    end else if (!init_done) begin
      init_addr <= init_addr + 1'b1;
      if (&init_addr) init_done <= 1'b1;
    end
  end

  assign hdrReady = init_done & ~(ackFifoAFull | wrDoneFifoAFull | rdDoneFifoAFull |
                                  offloadFifoAFull | eopFifoAFull);
  assign accept   = hdrValid & hdrReady;
  assign legal    = op_legal(hdrControl);
  assign send_tid = hdrData[SEND_TID_LSB +: TID_W];
  assign ack_tid  = hdrData[ACK_TID_LSB +: TID_W];

  assign s0_send = accept & legal & (hdrControl[3:0] == SEND);
  assign s0_ack  = accept & legal & (hdrControl[3:0] == ACK);
  assign s0_err  = accept & ~legal;

  assign reqValid         = accept & legal & (hdrControl[3:0] == REQ);
  assign reqInfo          = hdrData;
  assign ackFifoPush      = s0_ack;
  assign ackFifoDataIn    = hdrData[43:20];
  assign wrDoneFifoPush   = accept & legal & (hdrControl[3:0] == WR_DONE);
  assign wrDoneFifoDataIn = send_tid;
  assign rdDoneFifoPush   = accept & legal & (hdrControl[3:0] == RD_DONE);
  assign rdDoneFifoDataIn = send_tid;
  assign dataNumRd        = s0_send;
  assign dataNumRdAddr    = send_tid;

  // SEND stage S1 plus the one-deep forward of the previous S1 write.
  logic              s1_valid, fwd_valid;
  logic [TID_W-1:0]  s1_tid, fwd_tid;
  logic [CNT_W-1:0]  fwd_cnt, cnt_rdata, cur, nxt, wr_cnt;
  logic              sop, eop, s1_err;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cur    = (fwd_valid && fwd_tid == s1_tid) ? fwd_cnt : cnt_rdata;
    nxt    = cur + 1'b1;
    sop    = 1'b0;
    eop    = 1'b0;
    s1_err = 1'b0;
    wr_cnt = '0;
    if (s1_valid) begin
      if (dataNumRdData == '0 || nxt == '0) begin
        s1_err = 1'b1;
      end else begin
        sop    = (nxt == CNT_W'(1));
        eop    = (nxt == dataNumRdData);
        wr_cnt = eop ? '0 : nxt;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_tid    <= '0;
      fwd_valid <= 1'b0;
      fwd_tid   <= '0;
      fwd_cnt   <= '0;
    end else begin
      s1_valid  <= s0_send;
      s1_tid    <= send_tid;
      fwd_valid <= s1_valid;
      fwd_tid   <= s1_tid;
      fwd_cnt   <= wr_cnt;
    end
  end

  assign offloadFifoPush   = sop;
  assign offloadFifoDataIn = s1_tid;
  assign eopFifoPush       = eop;
  assign eopFifoDataIn     = s1_tid;

  gen_ram_2p #(.DEPTH(DEPTH), .WIDTH(CNT_W)) u_cnt_ram (
    .clk   (clock),
    .rst_n (reset),
    .we    (~init_done | s1_valid),
    .waddr (init_done ? s1_tid : init_addr),
    .wdata (init_done ? wr_cnt : '0),
    .re    (s0_send),
    .raddr (send_tid),
    .rdata (cnt_rdata)
  );

  // Queue table: the RAM is read-old, so a same-cycle write to the read address is bypassed here.
  logic              q_we, q_byp;
  logic [TID_W-1:0]  q_waddr;
  logic [QNUM_W-1:0] q_wdata, q_ram_rdata, q_byp_data;

  assign q_we    = ~init_done | s0_ack;
  assign q_waddr = init_done ? ack_tid : init_addr;
  assign q_wdata = init_done ? hdrData[QNUM_LSB +: QNUM_W] : '0;

  gen_ram_2p #(.DEPTH(DEPTH), .WIDTH(QNUM_W)) u_queue_ram (
    .clk   (clock),
    .rst_n (reset),
    .we    (q_we),
    .waddr (q_waddr),
    .wdata (q_wdata),
    .re    (queueNumRd),
    .raddr (queueNumRdAddr),
    .rdata (q_ram_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_byp      <= 1'b0;
      q_byp_data <= '0;
    end else if (queueNumRd) begin
      q_byp      <= q_we && (q_waddr == queueNumRdAddr);
      q_byp_data <= q_wdata;
    end
  end

  assign queueNumRdData = q_byp ? q_byp_data : q_ram_rdata;

  // Saturating error counter; an illegal S0 opcode and an S1 count error can land in the same cycle.
  logic [ERR_W-1:0] err_cnt;
  logic [ERR_W:0]   err_sum;

  assign err_sum = {1'b0, err_cnt} + {{ERR_W{1'b0}}, s0_err} + {{ERR_W{1'b0}}, s1_err};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err_cnt <= '0;
    else        err_cnt <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
  end

  assign initDone = init_done;
  assign errCount = err_cnt;

endmodule
